// File: rtl/ranger_pkg.sv
// Shared types and constants for the three-channel ultrasonic ranger.
package ranger_pkg;

  localparam int DIST_W = 21;
  localparam logic [DIST_W-1:0] DIST_NONE = 21'h1FFFFF;

  localparam logic [1:0] CH_LEFT  = 2'd0;
  localparam logic [1:0] CH_MID   = 2'd1;
  localparam logic [1:0] CH_RIGHT = 2'd2;

  typedef enum logic [2:0] {
    S_GAP,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_STORE
  } state_t;

  function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
    ch_onehot = 3'b001 << ch;
  endfunction

endpackage

// File: rtl/echo_edge_sync.sv
// Two-flop synchroniser for one raw echo line, followed by rise/fall detection
// on the synchronised level and its one-cycle-delayed copy.
module echo_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic echo,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= echo;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_dly;
  assign fall  = ~r_sync & r_dly;

endmodule

// File: rtl/ultrasonic_ranger.sv
// Round-robin HC-SR04 ranger: trigger one sensor, time its echo, convert to cm,
// then idle before the next channel. Left, mid and right are served in turn.
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int GAP_CYCLES     = 500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        echo_in,
  output logic [2:0]        trig_out,
  output logic [DIST_W-1:0] left_echo,
  output logic [DIST_W-1:0] mid_echo,
  output logic [DIST_W-1:0] right_echo,
  output logic [2:0]        dist_valid,
  output logic [2:0]        no_echo,
  output state_t            dbg_state,
  output logic [1:0]        dbg_ch,
  output logic [2:0]        dbg_echo_level
);

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_ch;
  logic [31:0]       r_cnt;
  logic [31:0]       r_sub;
  logic [DIST_W-1:0] r_cm;
  logic [2:0]        r_trig;
  logic [2:0]        r_valid;
  logic [2:0]        r_no_echo;
  logic [DIST_W-1:0] r_left;
  logic [DIST_W-1:0] r_mid;
  logic [DIST_W-1:0] r_right;

  logic [2:0]        w_level;
  logic [2:0]        w_rise;
  logic [2:0]        w_fall;
  logic [2:0]        w_ch_oh;
  logic              w_sel_rise;
  logic              w_sel_fall;
  logic              w_wrap;
  logic [DIST_W-1:0] w_cm_inc;
  logic [DIST_W-1:0] w_result;
  logic              w_timeout;

  for (genvar g = 0; g < 3; g++) begin : g_sync
    echo_edge_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .echo  (echo_in[g]),
      .level (w_level[g]),
      .rise  (w_rise[g]),
      .fall  (w_fall[g])
    );
  end

  assign w_ch_oh    = ch_onehot(r_ch);
  assign w_sel_rise = |(w_rise & w_ch_oh);
  assign w_sel_fall = |(w_fall & w_ch_oh);

  // The fall cycle itself is still counted, so the result uses the
  // post-increment cm value to give floor(high_cycles / CYCLES_PER_CM).
  assign w_wrap   = (r_sub == 32'(CYCLES_PER_CM - 1));
  assign w_cm_inc = (w_wrap && (r_cm != DIST_NONE)) ? r_cm + DIST_W'(1) : r_cm;

  always_comb begin
    w_state_next = r_state;
    w_result     = DIST_NONE;
    w_timeout    = 1'b0;
    case (r_state)
      S_GAP: begin
        if (r_cnt == 32'(GAP_CYCLES - 1)) w_state_next = S_TRIG;
      end
      S_TRIG: begin
        if (r_cnt == 32'(TRIG_CYCLES - 1)) w_state_next = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (w_sel_rise) begin
          w_state_next = S_MEASURE;
        end else if (r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          w_state_next = S_STORE;
          w_timeout    = 1'b1;
        end
      end
      S_MEASURE: begin
        if (w_sel_fall) begin
          w_state_next = S_STORE;
          w_result     = w_cm_inc;
        end else if (r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          w_state_next = S_STORE;
          w_timeout    = 1'b1;
        end
      end
      S_STORE:  w_state_next = S_GAP;
      default:  w_state_next = S_GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_GAP;
      r_ch      <= CH_LEFT;
      r_cnt     <= '0;
      r_sub     <= '0;
      r_cm      <= '0;
      r_trig    <= '0;
      r_valid   <= '0;
      r_no_echo <= '0;
      r_left    <= '0;
      r_mid     <= '0;
      r_right   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + 32'd1;
      if (r_state == S_MEASURE) begin
        r_sub <= w_wrap ? '0 : r_sub + 32'd1;
        r_cm  <= w_cm_inc;
      end else begin
        r_sub <= '0;
        r_cm  <= '0;
      end
      r_trig  <= (w_state_next == S_TRIG) ? w_ch_oh : 3'b000;
      r_valid <= 3'b000;
      // Results land on entry to STORE so dist_valid coincides with the new value.
      if (w_state_next == S_STORE) begin
        r_valid   <= w_ch_oh;
        r_no_echo <= (r_no_echo & ~w_ch_oh) | (w_timeout ? w_ch_oh : 3'b000);
        case (r_ch)
          CH_LEFT:  r_left  <= w_result;
          CH_MID:   r_mid   <= w_result;
          CH_RIGHT: r_right <= w_result;
          default:  ;
        endcase
      end
      if (r_state == S_STORE) r_ch <= (r_ch == CH_RIGHT) ? CH_LEFT : r_ch + 2'd1;
    end
  end

  assign trig_out       = r_trig;
  assign dist_valid     = r_valid;
  assign no_echo        = r_no_echo;
  assign left_echo      = r_left;
  assign mid_echo       = r_mid;
  assign right_echo     = r_right;
  assign dbg_state      = r_state;
  assign dbg_ch         = r_ch;
  assign dbg_echo_level = w_level;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Randomised bench for ultrasonic_ranger with scaled-down timing parameters and
// a width-to-centimetre reference model.
module tb_ultrasonic_ranger;
  import ranger_pkg::*;

  localparam int TRIG = 5;
  localparam int CPM  = 29;
  localparam int TMO  = 3000;
  localparam int GAP  = 50;

  localparam int M_ECHO   = 0;
  localparam int M_SILENT = 1;
  localparam int M_STUCK  = 2;
  localparam int N_SCEN   = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        echo_in = 3'b000;
  logic [2:0]        trig_out;
  logic [DIST_W-1:0] left_echo;
  logic [DIST_W-1:0] mid_echo;
  logic [DIST_W-1:0] right_echo;
  logic [2:0]        dist_valid;
  logic [2:0]        no_echo;
  state_t            dbg_state;
  logic [1:0]        dbg_ch;
  logic [2:0]        dbg_echo_level;

  int n_checks = 0;
  int n_errors = 0;

  logic [DIST_W-1:0] exp_q[$];
  logic              exp_to_q[$];
  logic [DIST_W-1:0] exp_dist[3];
  logic [2:0]        exp_no_echo;

  int sc_mode[N_SCEN];
  int sc_d[N_SCEN];
  int sc_w[N_SCEN];
  bit sc_dis[N_SCEN];

  ultrasonic_ranger #(
    .TRIG_CYCLES    (TRIG),
    .CYCLES_PER_CM  (CPM),
    .TIMEOUT_CYCLES (TMO),
    .GAP_CYCLES     (GAP)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .echo_in        (echo_in),
    .trig_out       (trig_out),
    .left_echo      (left_echo),
    .mid_echo       (mid_echo),
    .right_echo     (right_echo),
    .dist_valid     (dist_valid),
    .no_echo        (no_echo),
    .dbg_state      (dbg_state),
    .dbg_ch         (dbg_ch),
    .dbg_echo_level (dbg_echo_level)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: whole cm of the high time, or no-echo when there is no usable rise
  // or the pulse outlasts the timeout (a pulse exactly TMO long still counts).
  function automatic logic [DIST_W-1:0] model_dist(input int mode, input int w);
    if (mode != M_ECHO || w > TMO) return DIST_NONE;
    return DIST_W'(w / CPM);
  endfunction

  function automatic logic model_to(input int mode, input int w);
    return (mode != M_ECHO) || (w > TMO);
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, "_left"},  left_echo,  exp_dist[0]);
    check_eq({tag, "_mid"},   mid_echo,   exp_dist[1]);
    check_eq({tag, "_right"}, right_echo, exp_dist[2]);
    check_eq({tag, "_noecho"}, no_echo,   exp_no_echo);
  endtask

  task automatic wait_trig(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < GAP + TRIG + 100; i++) begin
      @(posedge clk); #1;
      if (trig_out != 3'b000) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic drive_echo(input int ch, input int d, input int w, input bit distract);
    int other;
    other = (ch + 1) % 3;
    @(negedge clk);
    if (distract) echo_in[other] = 1'b1;
    repeat (d) @(negedge clk);
    echo_in[other] = 1'b0;
    echo_in[ch] = 1'b1;
    repeat (w) @(negedge clk);
    echo_in[ch] = 1'b0;
  endtask

  task automatic wait_valid(input int ch);
    int n;
    logic [DIST_W-1:0] e;
    logic t;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (dist_valid == 3'b000 && n < 2 * TMO + 200);
    e = exp_q.pop_front();
    t = exp_to_q.pop_front();
    check_eq("valid_seen", 32'(dist_valid != 3'b000), 1);
    if (dist_valid == 3'b000) return;
    exp_dist[ch]    = e;
    exp_no_echo[ch] = t;
    check_eq("valid_onehot", dist_valid, 32'(1) << ch);
    check_outputs("result");
    @(posedge clk); #1;
    check_eq("valid_pulse", dist_valid, 0);
  endtask

  task automatic run_meas(input int ch, input int mode, input int d, input int w, input bit distract);
    bit ok;
    int width;
    exp_q.push_back(model_dist(mode, w));
    exp_to_q.push_back(model_to(mode, w));
    if (mode == M_STUCK) echo_in[ch] = 1'b1;
    wait_trig(ok);
    check_eq("trig_seen", 32'(ok), 1);
    if (!ok) begin
      void'(exp_q.pop_front());
      void'(exp_to_q.pop_front());
      return;
    end
    check_eq("trig_onehot", trig_out, 32'(1) << ch);
    width = 0;
    do begin
      width++;
      @(posedge clk); #1;
    end while (trig_out != 3'b000 && width < 1000);
    check_eq("trig_width", width, TRIG);
    if (mode == M_STUCK) check_eq("stuck_level", dbg_echo_level[ch], 1);
    fork
      begin
        if (mode == M_ECHO) drive_echo(ch, d, w, distract);
      end
      begin
        wait_valid(ch);
      end
    join
    if (mode == M_STUCK) echo_in[ch] = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    int dummy;
    for (int i = 0; i < N_SCEN; i++) begin
      sc_mode[i] = M_ECHO;
      sc_d[i]    = $urandom_range(0, 100);
      sc_w[i]    = $urandom_range(1, TMO);
      sc_dis[i]  = (i % 3 == 0);
    end
    sc_d[0] = 100;  sc_w[0] = 2900;
    sc_w[1] = CPM - 1;
    sc_mode[2] = M_SILENT;
    sc_d[3] = $urandom_range(5, 60);
    sc_w[4] = CPM;
    sc_w[5] = 3 * CPM;
    sc_mode[6] = M_STUCK;
    sc_w[7] = 2 * CPM - 1;
    sc_w[8] = TMO;
    sc_d[9] = $urandom_range(5, 60);  sc_w[9] = TMO + 1;
    sc_w[10] = $urandom_range(TMO + 1, TMO + 10);
    exp_dist = '{default: '0};
    exp_no_echo = 3'b000;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_trig", trig_out, 0);
    check_eq("rst_valid", dist_valid, 0);
    check_outputs("rst");
    check_eq("rst_state", 32'(dbg_state), 32'(S_GAP));
    check_eq("rst_ch", dbg_ch, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N_SCEN; i++) begin
      run_meas(i % 3, sc_mode[i], sc_d[i], sc_w[i], sc_dis[i]);
    end

    // Reset during a left measurement discards everything.
    wait_trig(ok);
    check_eq("pre_rst_trig", trig_out, 1);
    fork
      drive_echo(0, 10, 200, 1'b0);
      begin
        n = 0;
        while (dbg_state != S_MEASURE && n < TRIG + 500) begin
          @(posedge clk); #1;
          n++;
        end
        check_eq("reach_measure", 32'(dbg_state), 32'(S_MEASURE));
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_dist = '{default: '0};
        exp_no_echo = 3'b000;
        check_eq("mrst_trig", trig_out, 0);
        check_eq("mrst_valid", dist_valid, 0);
        check_outputs("mrst");
        check_eq("mrst_state", 32'(dbg_state), 32'(S_GAP));
        check_eq("mrst_ch", dbg_ch, 0);
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (trig_out == 3'b000 && n < GAP + 100);
    check_eq("gap_after_rst", n, GAP);
    check_eq("first_trig_left", trig_out, 1);

    // Reset while the trigger is high drops it at the next edge.
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("trig_rst_drop", trig_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    dummy = $urandom_range(0, 40);
    run_meas(0, M_ECHO, dummy, 5 * CPM + 3, 1'b0);
    run_meas(1, M_ECHO, dummy, $urandom_range(1, TMO), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
